// File: rtl/sponge_absorb.sv
// Sponge absorb phase: pads and XORs message words into the rate,
// running the external permutation after every block.
module sponge_absorb #(
    parameter int RWIDTH    = 32,
    parameter int CWIDTH    = 320,
    parameter int LEN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic [RWIDTH-1:0]    r_init,
    input  logic [CWIDTH-1:0]    c_init,
    input  logic [RWIDTH-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 perm_go,
    output logic [RWIDTH-1:0]    perm_r,
    output logic [CWIDTH-1:0]    perm_c,
    input  logic [RWIDTH-1:0]    perm_rout,
    input  logic [CWIDTH-1:0]    perm_cout,
    input  logic                 perm_done,
    output logic [RWIDTH-1:0]    r_out,
    output logic [CWIDTH-1:0]    c_out,
    output logic                 absorb_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PADBLK,
        PERM,
        CHECK,
        DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] RW = LEN_WIDTH'(RWIDTH);
    localparam logic [RWIDTH-1:0] ONES = {RWIDTH{1'b1}};
    localparam logic [RWIDTH-1:0] TOP  = {1'b1, {(RWIDTH-1){1'b0}}};

    state_t               state, state_d;
    logic [RWIDTH-1:0]    rate, rate_d;
    logic [CWIDTH-1:0]    cap, cap_d;
    logic [LEN_WIDTH-1:0] remaining, remaining_d;
    logic                 pad_pending, pad_pending_d;

    logic [LEN_WIDTH-1:0] take;
    logic [RWIDTH-1:0]    blk;

    // Shifts by take==RWIDTH yield zero, so a full word keeps every
    // bit and gets no pad bit without a separate branch.
    always_comb begin
        take = (remaining >= RW) ? RW : remaining;
        blk  = (in_data & ~(ONES >> take)) | (TOP >> take);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rate        <= '0;
            cap         <= '0;
            remaining   <= '0;
            pad_pending <= 1'b0;
        end else begin
            state       <= state_d;
            rate        <= rate_d;
            cap         <= cap_d;
            remaining   <= remaining_d;
            pad_pending <= pad_pending_d;
        end
    end

    always_comb begin
        state_d       = state;
        rate_d        = rate;
        cap_d         = cap;
        remaining_d   = remaining;
        pad_pending_d = pad_pending;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    rate_d        = r_init;
                    cap_d         = c_init;
                    remaining_d   = msg_len;
                    pad_pending_d = (msg_len == '0);
                    state_d       = (msg_len != '0) ? FETCH : PADBLK;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    rate_d      = rate ^ blk;
                    remaining_d = remaining - take;
                    if (take == RW && remaining == RW)
                        pad_pending_d = 1'b1;
                    state_d = PERM;
                end
            end
            PADBLK: begin
                rate_d        = rate ^ TOP;
                pad_pending_d = 1'b0;
                state_d       = PERM;
            end
            PERM: begin
                if (perm_done) begin
                    rate_d  = perm_rout;
                    cap_d   = perm_cout;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (remaining != '0)
                    state_d = FETCH;
                else if (pad_pending)
                    state_d = PADBLK;
                else
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state == FETCH);
    assign perm_go     = (state == PERM);
    assign absorb_done = (state == DONE);
    assign perm_r      = rate;
    assign perm_c      = cap;
    assign r_out       = rate;
    assign c_out       = cap;

endmodule

// File: tb/tb_sponge_absorb.sv
// Bench for sponge_absorb: stub permutation (rout=rin, cout=cin+1,
// 3-cycle latency) and a queue of expected results per absorb.
module tb_sponge_absorb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [19:0]  msg_len = '0;
    logic [31:0]  r_init = '0;
    logic [319:0] c_init = '0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         perm_go;
    logic [31:0]  perm_r;
    logic [319:0] perm_c;
    logic [31:0]  perm_rout;
    logic [319:0] perm_cout;
    logic         perm_done;
    logic [31:0]  r_out;
    logic [319:0] c_out;
    logic         absorb_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  r;
        logic [319:0] c;
        int           nperm;
        int           nwords;
    } exp_t;

    exp_t sb[$];

    sponge_absorb #(
        .RWIDTH(32),
        .CWIDTH(320),
        .LEN_WIDTH(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .msg_len(msg_len),
        .r_init(r_init),
        .c_init(c_init),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .perm_go(perm_go),
        .perm_r(perm_r),
        .perm_c(perm_c),
        .perm_rout(perm_rout),
        .perm_cout(perm_cout),
        .perm_done(perm_done),
        .r_out(r_out),
        .c_out(c_out),
        .absorb_done(absorb_done)
    );

    always #5 clk = ~clk;

    // Stub permutation, held in reset while perm_go is low
    logic [3:0] pcnt = '0;
    always @(posedge clk) begin
        if (!perm_go) pcnt <= '0;
        else          pcnt <= pcnt + 4'd1;
    end
    assign perm_done = perm_go && (pcnt == 4'd3);
    assign perm_rout = perm_r;
    assign perm_cout = perm_c + 320'd1;

    int perm_runs = 0;
    int accepted = 0;
    int ready_cycles = 0;
    logic prev_go = 1'b0;

    always @(negedge clk) begin
        prev_go <= perm_go;
        if (perm_go && !prev_go) perm_runs <= perm_runs + 1;
        if (in_ready) ready_cycles <= ready_cycles + 1;
    end

    always @(posedge clk) begin
        if (in_valid && in_ready) accepted <= accepted + 1;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 0", in_ready);
        end
        if (perm_go !== 1'b0) begin
            errors++;
            $display("FAIL reset_perm_go: got %0b want 0", perm_go);
        end
        if (absorb_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %0b want 0", absorb_done);
        end
        if (r_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_r_out: got %0h want 0", r_out);
        end
        if (c_out !== 320'h0) begin
            errors++;
            $display("FAIL reset_c_out: got %0h want 0", c_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_absorb(
        input logic [19:0]  len,
        input logic [31:0]  w0,
        input logic [31:0]  w1,
        input int           nw,
        input int           gap,
        input bit           poke,
        input logic [31:0]  er,
        input logic [319:0] ec,
        input int           eperm,
        input string        name
    );
        exp_t e;
        int p0, a0, r0, t;
        sb.push_back('{r: er, c: ec, nperm: eperm, nwords: nw});
        p0 = perm_runs;
        a0 = accepted;
        r0 = ready_cycles;
        @(negedge clk);
        msg_len = len;
        r_init  = '0;
        c_init  = '0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL %s_ready_timeout: got 0 want 1", name);
                break;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_hold: got %0b want 1",
                             name, in_ready);
                end
            end
            in_data  = (i == 0) ? w0 : w1;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = '0;
            if (poke && i == 0) begin
                t = 0;
                while (!perm_go && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                start   = 1'b1;
                msg_len = 20'd16;
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (!absorb_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!absorb_done) begin
            errors++;
            $display("FAIL %s_done_timeout: got 0 want 1", name);
        end
        e = sb.pop_front();
        checks += 3;
        if (r_out !== e.r) begin
            errors++;
            $display("FAIL %s_r_out: got %0h want %0h", name, r_out, e.r);
        end
        if (c_out !== e.c) begin
            errors++;
            $display("FAIL %s_c_out: got %0h want %0h", name, c_out, e.c);
        end
        if (perm_runs - p0 != e.nperm) begin
            errors++;
            $display("FAIL %s_perm_runs: got %0d want %0d",
                     name, perm_runs - p0, e.nperm);
        end
        checks++;
        if (e.nwords == 0) begin
            if (ready_cycles - r0 != 0) begin
                errors++;
                $display("FAIL %s_ready_cycles: got %0d want 0",
                         name, ready_cycles - r0);
            end
        end else if (accepted - a0 != e.nwords) begin
            errors++;
            $display("FAIL %s_accepted: got %0d want %0d",
                     name, accepted - a0, e.nwords);
        end
    endtask

    task automatic test_empty();
        run_absorb(20'd0, 32'h0, 32'h0, 0, 0, 1'b0,
                   32'h8000_0000, 320'd1, 1, "empty");
    endtask

    task automatic test_partial();
        run_absorb(20'd16, 32'hABCD_1234, 32'h0, 1, 0, 1'b0,
                   32'hABCD_8000, 320'd1, 1, "partial");
    endtask

    task automatic test_back_to_back();
        run_absorb(20'd64, 32'h1111_1111, 32'h2222_2222, 2, 0, 1'b0,
                   32'hB333_3333, 320'd3, 3, "b2b");
    endtask

    task automatic test_stall();
        run_absorb(20'd64, 32'h1111_1111, 32'h2222_2222, 2, 5, 1'b0,
                   32'hB333_3333, 320'd3, 3, "stall");
    endtask

    task automatic test_start_in_perm();
        run_absorb(20'd64, 32'h1111_1111, 32'h2222_2222, 2, 0, 1'b1,
                   32'hB333_3333, 320'd3, 3, "poke");
    endtask

    task automatic test_reset_mid();
        int t;
        @(negedge clk);
        msg_len = 20'd64;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_data  = 32'h1111_1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!perm_go && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!perm_go) begin
            errors++;
            $display("FAIL rstmid_perm_go_start: got 0 want 1");
        end
        reset = 1'b1;
        #1;
        checks += 5;
        if (perm_go !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_perm_go: got %0b want 0", perm_go);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %0b want 0", in_ready);
        end
        if (absorb_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done: got %0b want 0", absorb_done);
        end
        if (r_out !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_r_out: got %0h want 0", r_out);
        end
        if (c_out !== 320'h0) begin
            errors++;
            $display("FAIL rstmid_c_out: got %0h want 0", c_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_absorb(20'd16, 32'hABCD_1234, 32'h0, 1, 0, 1'b0,
                   32'hABCD_8000, 320'd1, 1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_empty();
        test_partial();
        test_back_to_back();
        test_stall();
        test_start_in_perm();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sponge_absorb.md
Name: sponge_absorb

Overview:
Absorb phase of the sponge construction, the input-side counterpart of the squeeze block. It accepts a message of msg_len bits as a stream of RWIDTH-bit words and XORs each padded word into the rate register. It runs the external permutation (G core) after every block. The final {rate, capacity} state is handed to the squeeze stage.

Parameters:
RWIDTH, 32, rate width in bits (one message word per block)
CWIDTH, 320, capacity width in bits
LEN_WIDTH, 20, width of the message length counter (bits)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  begin absorb; sampled only in IDLE or DONE
msg_len  in  LEN_WIDTH  message length in bits; latched on start
r_init  in  RWIDTH  initial rate value; latched on start
c_init  in  CWIDTH  initial capacity value; latched on start
in_data  in  RWIDTH  message word, MSB-first; a partial word is MSB-aligned
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
perm_go  out  1  permutation run request; permutation is held in reset while low
perm_r  out  RWIDTH  rate into permutation
perm_c  out  CWIDTH  capacity into permutation
perm_rout  in  RWIDTH  rate from permutation
perm_cout  in  CWIDTH  capacity from permutation
perm_done  in  1  permutation result valid
r_out  out  RWIDTH  final rate
c_out  out  CWIDTH  final capacity
absorb_done  out  1  high in DONE; r_out/c_out valid

Behaviour:
- Reset: state IDLE. All registers clear: rate, cap, remaining, pad_pending. All outputs 0.
- The FSM is registered; every output is driven from registers or from the state decode. perm_r/perm_c drive the rate/cap registers continuously. r_out/c_out drive the same registers.
- IDLE/DONE, on start: rate<=r_init, cap<=c_init, remaining<=msg_len, pad_pending<=(msg_len==0), absorb_done<=0. Next state is FETCH if msg_len>0, else PADBLK.
- FETCH: in_ready=1.
  - On in_valid: take=min(remaining,RWIDTH).
  - blk = in_data with bits [RWIDTH-1-take:0] forced to 0.
  - If take<RWIDTH, also set bit RWIDTH-1-take (10* padding).
  - rate<=rate^blk; remaining<=remaining-take.
  - If take==RWIDTH and remaining==RWIDTH, set pad_pending.
  - Go to PERM.
- In every state other than FETCH, in_ready=0 and in_valid is ignored.
- PADBLK: rate<=rate^(1<<(RWIDTH-1)); pad_pending<=0; go to PERM.
- PERM: perm_go=1.
  - On perm_done: rate<=perm_rout, cap<=perm_cout; go to CHECK.
  - perm_go is low in CHECK, so every permutation run is separated by at least one low cycle.
- CHECK:
  - remaining>0: go to FETCH.
  - else pad_pending: go to PADBLK.
  - else: go to DONE.
- DONE: absorb_done=1, held until the next start or reset.
- Latency per block: FETCH wait (>=1) + permutation latency + 1 (CHECK).
- Blocks absorbed = ceil(msg_len/RWIDTH), plus one extra pad block if msg_len is a multiple of RWIDTH (including 0).
- start in FETCH/PADBLK/PERM/CHECK: ignored.
- Reset mid-operation: immediate return to IDLE. perm_go drops asynchronously. No partial result is exposed.
- Width rules: remaining is unsigned LEN_WIDTH, never underflows since take<=remaining. All XOR is bitwise on RWIDTH.

Test Plan:
All scenarios use RWIDTH=32, CWIDTH=320, r_init=0, c_init=0. Stub permutation: rout=rin, cout=cin+1, perm_done 3 cycles after perm_go rises.
1. msg_len=0, start -> no in_ready pulse, one permutation, absorb_done=1, r_out=32'h8000_0000, c_out=1.
2. msg_len=16, in_data=32'hABCD_1234 -> one block, r_out=32'hABCD_8000, c_out=1.
3. msg_len=64, words 32'h1111_1111 then 32'h2222_2222 -> three permutations (two data, one pad), r_out=32'hB333_3333, c_out=3.
4. Same stimulus as 3 with in_valid low 5 cycles between words:
   - in_ready stays high while waiting.
   - Words are accepted only on valid&ready.
   - Result is identical to 3.
5. start pulsed during PERM of scenario 3 -> ignored; the result matches 3.
   perm_go is low for >=1 cycle between each of the three runs.
6. reset asserted mid-PERM of scenario 3:
   - In the same cycle: state IDLE, perm_go=0, absorb_done=0, r_out=0, c_out=0.
   - A subsequent scenario 2 run gives the scenario 2 result.
